vga_scan_out: RTL

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA timing generator and pixel scan-out.
// A clock divider produces a one-clk pixel tick that advances the x/y raster
// counters. x/y go out to the frame buffer; the returned pixel is merged with
// decoded sync/blanking through a two-stage pipeline so that colour and sync
// reach the pins together, two clk after each counter advance.

module vga_scan_out #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  x,
    output logic [9:0]  y,
    input  logic [15:0] i_pix_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        o_frame_start
);

    // Raster geometry, all held as 10-bit unsigned values.
    localparam logic [9:0] H_TOTAL    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_LAST     = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST     = V_TOTAL - 10'd1;
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0] r_div;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_frame_start;

    logic       r_tick_d1;
    logic       r_tick_d2;

    logic       r_s1_hs_n;
    logic       r_s1_vs_n;
    logic       r_s1_video_on;

    logic [3:0] r_vga_r;
    logic [3:0] r_vga_g;
    logic [3:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;

    logic       w_pix_tick;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_video_on;

    // Pixel tick on the last divider count; sync/blank decode of the held counters.
    always_comb begin
        w_pix_tick = (r_div == DIV_LAST);
        w_hs_n     = !((r_x >= HS_START) && (r_x < HS_END));
        w_vs_n     = !((r_y >= VS_START) && (r_y < VS_END));
        w_video_on = (r_x < H_ACT) && (r_y < V_ACT);
    end

    // Divider and raster counters; frame_start flags the wrap to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= 4'd0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_pix_tick) begin
                r_div <= 4'd0;
                if (r_x == H_LAST) begin
                    r_x <= 10'd0;
                    if (r_y == V_LAST) begin
                        r_y           <= 10'd0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_y <= r_y + 10'd1;
                    end
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    // Tick delay flags mark the stage-1 edge and the output-load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_d1 <= 1'b0;
            r_tick_d2 <= 1'b0;
        end else begin
            r_tick_d1 <= w_pix_tick;
            r_tick_d2 <= r_tick_d1;
        end
    end

    // Stage 1 captures the decode one clk after the counters advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hs_n     <= 1'b1;
            r_s1_vs_n     <= 1'b1;
            r_s1_video_on <= 1'b0;
        end else if (r_tick_d1) begin
            r_s1_hs_n     <= w_hs_n;
            r_s1_vs_n     <= w_vs_n;
            r_s1_video_on <= w_video_on;
        end
    end

    // Output registers load sync and blanked colour together, two clk after advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_r  <= 4'd0;
            r_vga_g  <= 4'd0;
            r_vga_b  <= 4'd0;
            r_vga_hs <= 1'b1;
            r_vga_vs <= 1'b1;
        end else if (r_tick_d2) begin
            r_vga_hs <= r_s1_hs_n;
            r_vga_vs <= r_s1_vs_n;
            if (r_s1_video_on) begin
                r_vga_r <= i_pix_data[15:12];
                r_vga_g <= i_pix_data[10:7];
                r_vga_b <= i_pix_data[4:1];
            end else begin
                r_vga_r <= 4'd0;
                r_vga_g <= 4'd0;
                r_vga_b <= 4'd0;
            end
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign vga_r         = r_vga_r;
    assign vga_g         = r_vga_g;
    assign vga_b         = r_vga_b;
    assign vga_hs        = r_vga_hs;
    assign vga_vs        = r_vga_vs;
    assign o_frame_start = r_frame_start;

endmodule
